// File: rtl/hazard_ctrl.sv
// Hazard control for the 5-stage pipeline: forwarding, load-use interlock, branch flush, memory-wait FSM.
// Optional performance counters are built only when HAZARD_PERF_CNT_EN is defined.
module hazard_ctrl #(
   parameter int MAX_WAIT = 16,
   parameter int CNT_W    = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [4:0]       rs_D,
   input  logic [4:0]       rt_D,
   input  logic [4:0]       rs_E,
   input  logic [4:0]       rt_E,
   input  logic [4:0]       write_reg_E,
   input  logic             reg_write_E,
   input  logic             mem_to_reg_E,
   input  logic [4:0]       write_reg_M,
   input  logic             reg_write_M,
   input  logic [4:0]       write_reg_W,
   input  logic             reg_write_W,
   input  logic             pc_src_M,
   input  logic             mem_access_M,
   input  logic             mem_ready,
   input  logic             err_clr,
   output logic [1:0]       forward_a_E,
   output logic [1:0]       forward_b_E,
   output logic             stall_F,
   output logic             stall_D,
   output logic             stall_E,
   output logic             stall_M,
   output logic             flush_D,
   output logic             flush_E,
   output logic             flush_M,
   output logic             flush_W,
   output logic             mem_timeout,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   localparam int WC_W = $clog2(MAX_WAIT + 1);

   typedef enum logic [1:0] {RUN, MEM_WAIT, ERR} state_t;

   state_t          r_state;
   logic [WC_W-1:0] r_wait_cnt;
   logic            r_mem_timeout;

   logic w_mw;
   logic w_lu;
   logic w_m_a, w_m_b, w_w_a, w_w_b;

   assign w_mw = mem_access_M && !mem_ready;
   assign w_lu = mem_to_reg_E && reg_write_E && (write_reg_E != 5'd0) &&
                 ((write_reg_E == rs_D) || (write_reg_E == rt_D));

   assign w_m_a = reg_write_M && (write_reg_M != 5'd0) && (write_reg_M == rs_E);
   assign w_m_b = reg_write_M && (write_reg_M != 5'd0) && (write_reg_M == rt_E);
   assign w_w_a = reg_write_W && (write_reg_W != 5'd0) && (write_reg_W == rs_E);
   assign w_w_b = reg_write_W && (write_reg_W != 5'd0) && (write_reg_W == rt_E);

   // Controls are gated by rst_n so they drop asynchronously, even mid-wait.
   always_comb begin
      forward_a_E = 2'b00;
      forward_b_E = 2'b00;
      stall_F = 1'b0;
      stall_D = 1'b0;
      stall_E = 1'b0;
      stall_M = 1'b0;
      flush_D = 1'b0;
      flush_E = 1'b0;
      flush_M = 1'b0;
      flush_W = 1'b0;
      if (rst_n) begin
         if (w_m_a)      forward_a_E = 2'b10;
         else if (w_w_a) forward_a_E = 2'b01;
         if (w_m_b)      forward_b_E = 2'b10;
         else if (w_w_b) forward_b_E = 2'b01;
         if (w_mw) begin
            // Freeze F..M; W gets a bubble. A pending branch waits in the held M register.
            stall_F = 1'b1;
            stall_D = 1'b1;
            stall_E = 1'b1;
            stall_M = 1'b1;
            flush_W = 1'b1;
         end else if (pc_src_M) begin
            flush_D = 1'b1;
            flush_E = 1'b1;
            flush_M = 1'b1;
         end else if (w_lu) begin
            stall_F = 1'b1;
            stall_D = 1'b1;
            flush_E = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= RUN;
         r_wait_cnt    <= '0;
         r_mem_timeout <= 1'b0;
      end else begin
         if (err_clr)
            r_mem_timeout <= 1'b0;
         case (r_state)
            RUN: begin
               if (w_mw) begin
                  r_state    <= MEM_WAIT;
                  r_wait_cnt <= WC_W'(1);
               end
            end
            MEM_WAIT: begin
               if (!w_mw) begin
                  r_state    <= RUN;
                  r_wait_cnt <= '0;
               end else if (r_wait_cnt == WC_W'(MAX_WAIT - 1)) begin
                  r_state       <= ERR;
                  r_mem_timeout <= 1'b1;
               end else begin
                  r_wait_cnt <= r_wait_cnt + WC_W'(1);
               end
            end
            ERR: begin
               if (!w_mw) begin
                  r_state    <= RUN;
                  r_wait_cnt <= '0;
               end
            end
            default: begin
               r_state    <= RUN;
               r_wait_cnt <= '0;
            end
         endcase
      end
   end

   assign mem_timeout = r_mem_timeout;

`ifdef HAZARD_PERF_CNT_EN
   logic [CNT_W-1:0] r_stall_cnt;
   logic [CNT_W-1:0] r_flush_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_stall_cnt <= '0;
         r_flush_cnt <= '0;
      end else begin
         if (stall_F) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
         if (flush_D) r_flush_cnt <= r_flush_cnt + CNT_W'(1);
      end
   end

   assign stall_cnt = r_stall_cnt;
   assign flush_cnt = r_flush_cnt;
`else
   assign stall_cnt = '0;
   assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: forwarding, load-use, branch priority, memory wait/timeout, async reset.
// Counter expectations follow HAZARD_PERF_CNT_EN (zero when the feature is not built).
module tb_hazard_ctrl;

`ifdef HAZARD_PERF_CNT_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic [4:0]  rs_D, rt_D, rs_E, rt_E, write_reg_E, write_reg_M, write_reg_W;
   logic        reg_write_E, mem_to_reg_E, reg_write_M, reg_write_W;
   logic        pc_src_M, mem_access_M, mem_ready, err_clr;
   logic [1:0]  forward_a_E, forward_b_E;
   logic        stall_F, stall_D, stall_E, stall_M;
   logic        flush_D, flush_E, flush_M, flush_W;
   logic        mem_timeout;
   logic [31:0] stall_cnt, flush_cnt;

   int n_chk  = 0;
   int n_fail = 0;

   hazard_ctrl #(.MAX_WAIT(16), .CNT_W(32)) dut (
      .clk(clk), .rst_n(rst_n),
      .rs_D(rs_D), .rt_D(rt_D), .rs_E(rs_E), .rt_E(rt_E),
      .write_reg_E(write_reg_E), .reg_write_E(reg_write_E), .mem_to_reg_E(mem_to_reg_E),
      .write_reg_M(write_reg_M), .reg_write_M(reg_write_M),
      .write_reg_W(write_reg_W), .reg_write_W(reg_write_W),
      .pc_src_M(pc_src_M), .mem_access_M(mem_access_M), .mem_ready(mem_ready), .err_clr(err_clr),
      .forward_a_E(forward_a_E), .forward_b_E(forward_b_E),
      .stall_F(stall_F), .stall_D(stall_D), .stall_E(stall_E), .stall_M(stall_M),
      .flush_D(flush_D), .flush_E(flush_E), .flush_M(flush_M), .flush_W(flush_W),
      .mem_timeout(mem_timeout), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   always #5 clk = ~clk;

   // {stall_F, stall_D, stall_E, stall_M, flush_D, flush_E, flush_M, flush_W}
   wire [7:0] w_sf = {stall_F, stall_D, stall_E, stall_M, flush_D, flush_E, flush_M, flush_W};

   localparam logic [7:0] SF_NONE = 8'b0000_0000;
   localparam logic [7:0] SF_LU   = 8'b1100_0100;
   localparam logic [7:0] SF_BR   = 8'b0000_1110;
   localparam logic [7:0] SF_MW   = 8'b1111_0001;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
      end
   endtask

   function automatic logic [31:0] cnt_exp(input int n);
      return PERF ? 32'(n) : 32'd0;
   endfunction

   task automatic idle_inputs();
      rs_D = 5'd0; rt_D = 5'd0; rs_E = 5'd0; rt_E = 5'd0;
      write_reg_E = 5'd0; reg_write_E = 1'b0; mem_to_reg_E = 1'b0;
      write_reg_M = 5'd0; reg_write_M = 1'b0;
      write_reg_W = 5'd0; reg_write_W = 1'b0;
      pc_src_M = 1'b0; mem_access_M = 1'b0; mem_ready = 1'b0; err_clr = 1'b0;
   endtask

   // Inputs change on the falling edge; outputs are sampled 1 ns later.
   task automatic next_cycle();
      @(negedge clk);
      #1;
   endtask

   int n_stalls;

   initial begin
      idle_inputs();
      rst_n = 1'b0;
      // Hazards asserted while in reset must not reach the outputs.
      rs_E = 5'd3; write_reg_M = 5'd3; reg_write_M = 1'b1;
      pc_src_M = 1'b1; mem_access_M = 1'b1;
      #12;
      chk("rst_sf", 32'(w_sf), 32'(SF_NONE));
      chk("rst_fwd_a", 32'(forward_a_E), 32'd0);
      chk("rst_timeout", 32'(mem_timeout), 32'd0);
      chk("rst_stall_cnt", stall_cnt, 32'd0);
      chk("rst_flush_cnt", flush_cnt, 32'd0);
      @(negedge clk);
      idle_inputs();
      rst_n = 1'b1;

      // add $3 in M, sub $4,$3,$5 in E
      next_cycle();
      rs_E = 5'd3; rt_E = 5'd5; write_reg_M = 5'd3; reg_write_M = 1'b1; #1;
      chk("fwd_a_M", 32'(forward_a_E), 32'b10);
      chk("fwd_b_none", 32'(forward_b_E), 32'b00);
      chk("fwd_sf_none", 32'(w_sf), 32'(SF_NONE));
      // one nop between: add in W
      next_cycle();
      idle_inputs(); rs_E = 5'd3; rt_E = 5'd5; write_reg_W = 5'd3; reg_write_W = 1'b1; #1;
      chk("fwd_a_W", 32'(forward_a_E), 32'b01);
      // destination $0 never forwards
      next_cycle();
      idle_inputs(); rs_E = 5'd0; rt_E = 5'd0; write_reg_M = 5'd0; reg_write_M = 1'b1;
      write_reg_W = 5'd0; reg_write_W = 1'b1; #1;
      chk("fwd_a_zero", 32'(forward_a_E), 32'b00);
      chk("fwd_b_zero", 32'(forward_b_E), 32'b00);
      // double match on B: M wins; A matches W only
      next_cycle();
      idle_inputs(); rs_E = 5'd9; rt_E = 5'd7; write_reg_M = 5'd7; reg_write_M = 1'b1;
      write_reg_W = 5'd7; reg_write_W = 1'b1; #1;
      chk("fwd_b_M_beats_W", 32'(forward_b_E), 32'b10);
      chk("fwd_a_nomatch", 32'(forward_a_E), 32'b00);
      // M matches but reg_write_M=0, W matches -> W
      next_cycle();
      reg_write_M = 1'b0; #1;
      chk("fwd_b_W_only", 32'(forward_b_E), 32'b01);

      // lw $2 in E, add $4,$2,$1 in D
      next_cycle();
      idle_inputs(); mem_to_reg_E = 1'b1; reg_write_E = 1'b1; write_reg_E = 5'd2;
      rs_D = 5'd2; rt_D = 5'd1; #1;
      chk("lu_sf", 32'(w_sf), 32'(SF_LU));
      // bubble in E, lw in M: no further stall
      next_cycle();
      idle_inputs(); rs_D = 5'd2; rt_D = 5'd1; write_reg_M = 5'd2; reg_write_M = 1'b1; #1;
      chk("lu_released", 32'(w_sf), 32'(SF_NONE));
      // add in E, lw in W
      next_cycle();
      idle_inputs(); rs_E = 5'd2; rt_E = 5'd1; write_reg_W = 5'd2; reg_write_W = 1'b1; #1;
      chk("lu_fwd_a_W", 32'(forward_a_E), 32'b01);
      chk("lu_stall_cnt", stall_cnt, cnt_exp(1));
      // load into $0 is not an interlock
      next_cycle();
      idle_inputs(); mem_to_reg_E = 1'b1; reg_write_E = 1'b1; write_reg_E = 5'd0; #1;
      chk("lu_zero_dest", 32'(w_sf), 32'(SF_NONE));

      // branch coinciding with load-use: branch wins
      next_cycle();
      idle_inputs(); mem_to_reg_E = 1'b1; reg_write_E = 1'b1; write_reg_E = 5'd6;
      rt_D = 5'd6; pc_src_M = 1'b1; #1;
      chk("br_over_lu", 32'(w_sf), 32'(SF_BR));
      next_cycle();
      idle_inputs(); #1;
      chk("br_flush_cnt", flush_cnt, cnt_exp(1));
      chk("br_stall_cnt", stall_cnt, cnt_exp(1));

      // branch pending during a memory wait acts after the wait
      next_cycle();
      pc_src_M = 1'b1; mem_access_M = 1'b1; mem_ready = 1'b0; #1;
      chk("mw_over_br", 32'(w_sf), 32'(SF_MW));
      next_cycle();
      mem_ready = 1'b1; #1;
      chk("br_after_mw", 32'(w_sf), 32'(SF_BR));
      next_cycle();
      idle_inputs(); #1;
      chk("br2_flush_cnt", flush_cnt, cnt_exp(2));

      // 3-cycle memory wait
      n_stalls = 0;
      for (int i = 0; i < 3; i++) begin
         next_cycle();
         mem_access_M = 1'b1; mem_ready = 1'b0; #1;
         chk("mw3_sf", 32'(w_sf), 32'(SF_MW));
         if (stall_F) n_stalls++;
      end
      next_cycle();
      mem_ready = 1'b1; #1;
      chk("mw3_done", 32'(w_sf), 32'(SF_NONE));
      chk("mw3_count", 32'(n_stalls), 32'd3);
      next_cycle();
      idle_inputs(); #1;
      chk("mw3_timeout", 32'(mem_timeout), 32'd0);
      chk("mw3_stall_cnt", stall_cnt, cnt_exp(5));

      // 20-cycle wait: timeout visible from cycle 17; err_clr in cycle 16 loses to the set
      for (int i = 1; i <= 20; i++) begin
         next_cycle();
         mem_access_M = 1'b1; mem_ready = 1'b0; err_clr = (i == 16); #1;
         chk($sformatf("to_sf_%0d", i), 32'(w_sf), 32'(SF_MW));
         if (i == 16 || i == 17)
            chk($sformatf("to_flag_%0d", i), 32'(mem_timeout), (i >= 17) ? 32'd1 : 32'd0);
      end
      next_cycle();
      err_clr = 1'b0; mem_ready = 1'b1; #1;
      chk("to_release", 32'(w_sf), 32'(SF_NONE));
      chk("to_sticky", 32'(mem_timeout), 32'd1);
      next_cycle();
      idle_inputs(); err_clr = 1'b1; #1;
      chk("to_before_clr", 32'(mem_timeout), 32'd1);
      next_cycle();
      err_clr = 1'b0; #1;
      chk("to_cleared", 32'(mem_timeout), 32'd0);
      chk("to_stall_cnt", stall_cnt, cnt_exp(25));

      // reset in the middle of a wait
      for (int i = 0; i < 3; i++) begin
         next_cycle();
         mem_access_M = 1'b1; mem_ready = 1'b0; #1;
      end
      chk("rw_pre", 32'(w_sf), 32'(SF_MW));
      #1 rst_n = 1'b0;
      #1;
      chk("rw_async_sf", 32'(w_sf), 32'(SF_NONE));
      chk("rw_stall_cnt", stall_cnt, 32'd0);
      next_cycle();
      idle_inputs(); rst_n = 1'b1;
      next_cycle();
      chk("rw_after_sf", 32'(w_sf), 32'(SF_NONE));
      chk("rw_after_timeout", 32'(mem_timeout), 32'd0);
      chk("rw_after_flush_cnt", flush_cnt, 32'd0);
      // a fresh 1-cycle wait then release must behave as from RUN
      mem_access_M = 1'b1; #1;
      chk("rw_new_wait", 32'(w_sf), 32'(SF_MW));
      next_cycle();
      mem_ready = 1'b1; #1;
      chk("rw_new_done", 32'(w_sf), 32'(SF_NONE));
      next_cycle();
      idle_inputs(); #1;
      chk("rw_new_stall_cnt", stall_cnt, cnt_exp(1));

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Control-side counterpart of the 5-stage pipeline datapath. It consumes the datapath's register tags and write-enables, and returns forwarding selects plus per-stage stall and flush controls.
- Adds load-use interlock, flush on a taken branch resolved in M, and a data-memory wait handshake FSM with timeout detection.
- Sits beside the datapath in the CPU top level. Optional performance counters.

Parameters:
- MAX_WAIT, 16, max consecutive memory-wait cycles before timeout is flagged (>=2)
- CNT_W, 32, width of performance counters

Ports:
- clk  in  1  clock
- rst_n  in  1  async active-low reset
- rs_D  in  5  instr_D[25:21]
- rt_D  in  5  instr_D[20:16]
- rs_E  in  5  E-stage source A tag
- rt_E  in  5  E-stage source B tag
- write_reg_E  in  5  E-stage destination
- reg_write_E  in  1  E-stage writes register
- mem_to_reg_E  in  1  E-stage is a load
- write_reg_M  in  5  M-stage destination
- reg_write_M  in  1  M-stage writes register
- write_reg_W  in  5  W-stage destination
- reg_write_W  in  1  W-stage writes register
- pc_src_M  in  1  taken branch in M
- mem_access_M  in  1  M-stage load/store active
- mem_ready  in  1  data memory completes access this cycle
- err_clr  in  1  clears mem_timeout
- forward_a_E  out  2  00 reg file, 10 M result, 01 W result
- forward_b_E  out  2  same encoding for B
- stall_F, stall_D, stall_E, stall_M  out  1 each  hold pipeline register
- flush_D, flush_E, flush_M, flush_W  out  1 each  load bubble into register
- mem_timeout  out  1  sticky timeout flag
- stall_cnt  out  CNT_W  cycles with stall_F=1
- flush_cnt  out  CNT_W  taken-branch flush events

Behaviour:
- Reset values: state RUN, wait_cnt 0, mem_timeout 0, counters 0. While rst_n=0, all stall/flush outputs are 0 and forward selects are 00.
- Forwarding (combinational, same cycle):
  - forward_a_E=10 if reg_write_M && write_reg_M!=0 && write_reg_M==rs_E.
  - Otherwise 01 if reg_write_W && write_reg_W!=0 && write_reg_W==rs_E.
  - Otherwise 00. M beats W on a double match. Same rule for B with rt_E.
- Load-use: lu = mem_to_reg_E && reg_write_E && write_reg_E!=0 && (write_reg_E==rs_D || write_reg_E==rt_D). Produces stall_F=stall_D=flush_E=1 for exactly that cycle.
- Branch: pc_src_M produces flush_D=flush_E=flush_M=1 for that cycle. It overrides lu: no stall, and lu is ignored.
- Memory wait: mw = mem_access_M && !mem_ready, Mealy.
  - mw produces stall_F..stall_M=1 and flush_W=1.
  - All other flushes, lu stall, and branch flush are suppressed. A pending pc_src_M is held by the stalled M register and acts on the first non-wait cycle.
- Priority, highest first: mw > pc_src_M > lu.
- FSM:
  - RUN: mw -> MEM_WAIT with wait_cnt=1.
  - MEM_WAIT: mem_ready -> RUN, stalls drop the same cycle, wait_cnt=0. Otherwise wait_cnt++. When wait_cnt==MAX_WAIT-1 and still !mem_ready -> ERR, and mem_timeout is set next edge.
  - ERR: stalls continue while !mem_ready. mem_ready -> RUN. mem_timeout stays set.
- mem_timeout clears only on err_clr=1 or reset. If err_clr and a new timeout coincide, the set wins.
- mem_access_M dropping in MEM_WAIT/ERR is treated as completion: -> RUN.
- Counters:
  - stall_cnt increments each cycle stall_F=1.
  - flush_cnt increments each cycle pc_src_M takes effect, i.e. flush_D asserted.
  - Both wrap modulo 2^CNT_W.
- Reset mid-wait returns to RUN immediately. No residual stall.

Optional Feature:
- HAZARD_PERF_CNT_EN:
  - Defined: stall_cnt/flush_cnt registers exist as described.
  - Undefined: no counter flops; both outputs are constant 0. All other behaviour is identical.

Test Plan:
- add $3,$1,$2 then sub $4,$3,$5 back-to-back -> forward_a_E=10 in sub's E cycle. With one nop between -> 01. With write_reg=0 -> 00.
- lw $2,0($0) followed by add $4,$2,$1 -> one cycle stall_F=stall_D=flush_E=1, then forward_a_E=01. With HAZARD_PERF_CNT_EN, stall_cnt=1.
- pc_src_M=1 in the same cycle as lu=1 -> flush_D/E/M=1, stall_F=0, flush_cnt=1.
- mem_access_M=1 with mem_ready low 3 cycles -> stall_F..M and flush_W high exactly 3 cycles, state returns RUN, mem_timeout=0.
- mem_ready held low 20 cycles with MAX_WAIT=16 -> mem_timeout=1 after cycle 16, stalls held until mem_ready. err_clr pulse -> mem_timeout=0.
- rst_n asserted in MEM_WAIT -> all stalls 0 asynchronously. After release, state RUN and counters 0.
